// File: rtl/serial_bit_streamer.sv
// Purpose : parallel-to-serial front end; buffers one WIDTH-bit word and shifts it out one bit per clock.
// Latency : word accepted at edge k drives its first bit on dout after edge k+1 (idle shifter); no bubble between words.
// Backpr. : in_ready = !hold_full; a word offered while in_ready is low is ignored and must be held by the source.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   in_data    - parallel word, qualified by in_valid / in_ready
//   dout       - serial bit (0 when idle), dout_valid marks real data bits
//   last_bit   - dout carries the final bit of the current word
//   busy       - shifter active or holding buffer occupied
//   words_sent - count of words fully shifted out, wraps
module serial_bit_streamer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last_bit,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] words_q, words_d;

  logic             at_last;
  logic             do_load;
  logic             do_accept;
  logic [WIDTH-1:0] sreg_shifted;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    words_d     = words_q;

    at_last   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    // Loading on the last bit's edge is what keeps back-to-back words gap-free.
    do_load   = hold_full_q && ((state_q == IDLE) || at_last);
    do_accept = in_valid && in_ready;

    // Shift toward whichever end dout is taken from.
    if (MSB_FIRST) begin
      sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end

    if (do_load) begin
      sreg_d      = hold_q;
      cnt_d       = '0;
      state_d     = SHIFT;
      hold_full_d = 1'b0;
    end else if (state_q == SHIFT) begin
      if (at_last) begin
        state_d = IDLE;
      end else begin
        sreg_d = sreg_shifted;
        cnt_d  = cnt_q + CW'(1);
      end
    end

    // in_ready is low whenever hold is full, so accept never collides with load.
    if (do_accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    if (at_last) begin
      words_d = words_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
    end
  end

  // Outputs decode registers only; in_ready is additionally held low while reset is asserted.
  assign in_ready   = reset && !hold_full_q;
  assign dout_valid = (state_q == SHIFT);
  assign dout       = (state_q == SHIFT) && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign busy       = (state_q == SHIFT) || hold_full_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_serial_bit_streamer.sv
`timescale 1ns/100ps
module tb_serial_bit_streamer;

  logic        clk;
  logic        reset;
  logic [15:0] in_data0, in_data1;
  logic        in_valid0, in_valid1;
  logic        in_ready0, in_ready1;
  logic        dout0, dout1;
  logic        dv0, dv1;
  logic        last0, last1;
  logic        busy0, busy1;
  logic [7:0]  ws0, ws1;

  int tests = 0;
  int fails = 0;

  // expected entries: {last_bit, dout}
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  int popped0 = 0;
  int run0 = 0;
  int maxrun0 = 0;

  serial_bit_streamer #(.WIDTH(16), .MSB_FIRST(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .dout(dout0), .dout_valid(dv0), .last_bit(last0), .busy(busy0), .words_sent(ws0)
  );

  serial_bit_streamer #(.WIDTH(16), .MSB_FIRST(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .dout(dout1), .dout_valid(dv1), .last_bit(last1), .busy(busy1), .words_sent(ws1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input int d, input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      if (d == 0) q0.push_back({(i == 15), w[15-i]});
      else        q1.push_back({(i == 15), w[i]});
    end
  endtask

  // Offer a word at a negedge and keep it offered until it is taken on a rising edge.
  task automatic send(input int d, input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (d == 0) begin in_data0 = w; in_valid0 = 1'b1; end
    else        begin in_data1 = w; in_valid1 = 1'b1; end
    for (int c = 0; c < 100; c++) begin
      if ((d == 0) ? in_ready0 : in_ready1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      push_word(d, w);
      #1;
    end else begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready never high, expected high within 100 cycles");
    end
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (!busy0 && !busy1 && q0.size() == 0 && q1.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy0=%0b busy1=%0b q0=%0d q1=%0d, expected all idle", busy0, busy1, q0.size(), q1.size());
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_data0  = '0;
    in_data1  = '0;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    fork
      // Monitor: pops and compares whenever a DUT presents a valid bit.
      begin
        logic [1:0] e;
        forever begin
          @(negedge clk);
          if (dv0) begin
            run0++;
            if (run0 > maxrun0) maxrun0 = run0;
            if (q0.size() == 0) begin
              tests++; fails++;
              $display("FAIL dut0_unexpected_bit: dout_valid=1 dout=%0b, expected no valid bit", dout0);
            end else begin
              e = q0.pop_front();
              popped0++;
              chk("dut0_dout", dout0, e[0]);
              chk("dut0_last_bit", last0, e[1]);
            end
          end else begin
            run0 = 0;
            chk("dut0_idle_dout", dout0, 0);
            chk("dut0_idle_last", last0, 0);
          end
          if (dv1) begin
            if (q1.size() == 0) begin
              tests++; fails++;
              $display("FAIL dut1_unexpected_bit: dout_valid=1 dout=%0b, expected no valid bit", dout1);
            end else begin
              e = q1.pop_front();
              chk("dut1_dout", dout1, e[0]);
              chk("dut1_last_bit", last1, e[1]);
            end
          end else begin
            chk("dut1_idle_dout", dout1, 0);
          end
        end
      end
      // Main stimulus sequence.
      begin
        logic [7:0]  ws_base;
        logic [15:0] w;
        int          base;
        int          taken;
        bit          ok;

        // Reset state
        #3;
        chk("rst_in_ready", in_ready0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_dout_valid", dv0, 0);
        chk("rst_last_bit", last0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_words_sent", ws0, 0);
        #19 reset = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready0, 1);

        // Single word: latency, bit order, 16-cycle valid window, count
        maxrun0 = 0;
        send(0, 16'hB5BC);
        @(negedge clk);
        chk("latency_not_early", dv0, 0);
        @(negedge clk);
        chk("latency_first_bit", dv0, 1);
        wait_idle();
        chk("single_valid_len", maxrun0, 16);
        chk("single_words_sent", ws0, 8'd1);

        // Back-to-back: second word buffered while first shifts, 32 contiguous bits
        maxrun0 = 0;
        ws_base = ws0;
        send(0, 16'hB5BC);
        send(0, 16'hFFFF);
        chk("b2b_in_ready_low", in_ready0, 0);
        chk("b2b_busy", busy0, 1);
        wait_idle();
        chk("b2b_valid_len", maxrun0, 32);
        chk("b2b_words_delta", 8'(ws0 - ws_base), 8'd2);

        // LSB-first instance
        send(1, 16'h0001);
        wait_idle();
        chk("lsb_words_sent", ws1, 8'd1);

        // in_valid held with changing data; only words offered while ready are captured
        ws_base = ws0;
        taken = 0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          w = 16'h1357 ^ 16'(i * 241);
          in_data0 = w;
          in_valid0 = 1'b1;
          if (in_ready0) begin
            push_word(0, w);
            taken++;
          end
        end
        @(negedge clk);
        in_valid0 = 1'b0;
        wait_idle();
        chk("hold_words_delta", 8'(ws0 - ws_base), 8'(taken));

        // Reset at bit 7 with a second word buffered
        base = popped0;
        send(0, 16'hB5BC);
        send(0, 16'hAAAA);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
          if (popped0 >= base + 7) begin ok = 1'b1; break; end
          @(negedge clk);
          #1;
        end
        if (!ok) begin
          tests++; fails++;
          $display("FAIL midreset_wait: popped %0d bits, expected 7", popped0 - base);
        end
        #1 reset = 1'b0;
        #0.5;
        chk("midrst_dout", dout0, 0);
        chk("midrst_dout_valid", dv0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_words_sent", ws0, 0);
        chk("midrst_in_ready", in_ready0, 0);
        q0.delete();
        #0.5 reset = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("postrst_busy", busy0, 0);
        chk("postrst_words_sent", ws0, 0);

        // Counter wrap
        for (int i = 0; i < 255; i++) send(0, 16'(i * 16'h0101 + 16'h0F0F));
        wait_idle();
        chk("wrap_before", ws0, 8'hFF);
        send(0, 16'h8001);
        wait_idle();
        chk("wrap_after", ws0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/serial_bit_streamer.md
Name: serial_bit_streamer

Overview:
- Parallel-to-serial front end for the serial pattern detector.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers one word.
- Shifts each word out one bit per clock on a serial output that drives the detector's `din`.
- Back-to-back words stream with no idle gap. Reports word boundaries and a running word count.

Parameters:
- WIDTH, 16: word width in bits; must be ≥ 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- CNT_W, 8: width of the words_sent counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); release is synchronous to clk.
- in_data  input  WIDTH  parallel word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit; connects to the detector's din.
- dout_valid  output  1  dout carries a real data bit.
- last_bit  output  1  dout carries the final bit of the current word.
- busy  output  1  shifter active or holding buffer occupied.
- words_sent  output  CNT_W  count of words fully shifted out; wraps modulo 2^CNT_W.

Behaviour:
- Storage elements:
  - hold register (WIDTH) with flag hold_full.
  - shift register sreg (WIDTH).
  - bit counter cnt, ceil(log2(WIDTH)) bits.
  - state: IDLE or SHIFT.
  - words_sent register.
- Reset (reset = 0, asynchronous): state = IDLE, hold_full = 0, sreg = 0, cnt = 0, words_sent = 0.
  - Outputs during reset: in_ready = 0, dout = 0, dout_valid = 0, last_bit = 0, busy = 0.
  - After release: in_ready = 1 from the first cycle.
  - Reset mid-word discards the partial word and any buffered word; no further bits of either are emitted.
- in_ready = !hold_full, outside reset.
- Accept: at a rising edge with in_valid = 1 and in_ready = 1, in_data is copied into hold and hold_full goes to 1.
  - in_valid while in_ready = 0 is ignored; the word is not captured and the source must hold it.
- Load condition: hold_full = 1 and either state = IDLE, or state = SHIFT with cnt = WIDTH-1.
  - On a loading edge: sreg gets hold, cnt = 0, state = SHIFT, hold_full = 0.
- Shift: in SHIFT with cnt < WIDTH-1, each edge shifts sreg toward the output end and increments cnt.
  - MSB_FIRST = 1 shifts left; MSB_FIRST = 0 shifts right.
- End of word: in SHIFT with cnt = WIDTH-1 and no load this edge, state returns to IDLE.
- words_sent increments on every edge where state = SHIFT and cnt = WIDTH-1, regardless of any load on the same edge.
- Outputs are derived from registers only (no combinational path from in_valid or in_data):
  - dout = sreg[WIDTH-1] when MSB_FIRST = 1, else sreg[0]; forced to 0 in IDLE.
  - dout_valid = (state == SHIFT).
  - last_bit = (state == SHIFT) && (cnt == WIDTH-1).
  - busy = (state == SHIFT) || hold_full.
- Latency: a word accepted at edge k puts its first bit on dout in the cycle after edge k+1, provided the shifter was idle.
- Throughput: one bit per clock. If the next word is accepted before the current word's last edge, the next word's first bit directly follows the last bit, with no bubble.
- Simultaneous load and accept on the same edge cannot occur: in_ready is low whenever hold_full = 1.
- An idle line emits dout = 0 with dout_valid = 0. The downstream detector must not treat these idle zeros as pattern bits; gating with dout_valid is the integrator's responsibility.

Test Plan:
- Reset release, then in_data = 16'hB5BC with in_valid pulsed for 1 cycle → after 2 edges, dout emits 1,0,1,1,0,1,0,1,1,0,1,1,1,1,0,0 on consecutive cycles. dout_valid is high for exactly 16 cycles, last_bit is high on the 16th, and words_sent ends at 1.
- Back-to-back words 16'hB5BC then 16'hFFFF, with in_valid held high → the second word is accepted while the first is shifting, and its 16 ones follow the first word's final 0 with no gap. words_sent = 2, and in_ready is low from the second accept until that word loads.
- MSB_FIRST = 0, in_data = 16'h0001 → the first emitted bit is 1, followed by 15 zeros.
- reset driven to 0 for 1 ns at bit 7 of 16'hB5BC, with 16'hAAAA buffered → dout, dout_valid and busy go to 0 immediately and words_sent = 0. No remaining bits of either word appear after release.
- in_valid held high while in_ready = 0 with a changing in_data → only values presented while in_ready = 1 are emitted.
- 256 single-word transfers with CNT_W = 8 → words_sent wraps from 8'hFF to 8'h00.
